chunked_ripple_adder_seq: RTL
=============================

// Module: chunked_ripple_adder_seq
// PURPOSE
//  Multi-cycle wide adder: sequences WIDTH-bit operands through one CHUNK-bit
//  ripple-carry adder, one chunk per clock, LSB chunk first.
//  Carry is registered between chunks.
//  Sits upstream of / wraps the 2-bit ripple_carry_adder stage. Trades latency for area on wide adds.
// PARAMETERS
//  WIDTH  8  operand/sum width; must be a multiple of CHUNK (elaboration error otherwise)
//  CHUNK  2  bits added per cycle (matches ripple_carry_adder width)
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; samples a/b/cin when accepted
//  a      in   WIDTH  operand A
//  b      in   WIDTH  operand B
//  cin    in   1      carry-in to LSB chunk
//  busy   out  1      high while state==RUN
//  done   out  1      one-cycle pulse: sum/c_out just updated
//  sum    out  WIDTH  result; holds until next completion
//  c_out  out  1      carry out of MSB chunk; holds with sum
// BEHAVIOUR
//  Reset (rst_n=0, async, any state):
//   - state=IDLE; idx=0; carry=0; operand regs=0.
//   - sum=0, c_out=0, busy=0, done=0.
//   - Any in-flight add is discarded; no done pulse is issued for it.
//  N = WIDTH/CHUNK chunk cycles (default 4). idx width = clog2(N), min 1 bit.
//  FSM IDLE/RUN/DONE:
//   - IDLE: start=1 -> latch a,b; carry<=cin; idx<=0; ->RUN. start=0 -> stay.
//   - RUN: each edge adds chunk idx of A, chunk idx of B and carry (CHUNK+1-bit result).
//     Write the low CHUNK bits into partial-sum chunk idx; carry<=bit CHUNK; idx<=idx+1.
//   - RUN, last chunk (idx==N-1): sum<=full partial result; c_out<=final carry;
//     done<=1; ->DONE. No wrap of idx into a further chunk.
//   - DONE: done=1 for exactly this cycle.
//     start=1 -> accept new operands as in IDLE, ->RUN (back-to-back).
//     Otherwise ->IDLE.
//  Latency: start sampled at edge E0 -> done high in the cycle after edge EN (N edges later).
//   Throughput is one add per N+1 cycles back-to-back.
//  start while RUN: ignored. Latched operands are unaffected by a/b/cin changes after acceptance.
//  sum/c_out change only at completion (never show partial results); stable between done pulses.
//  Arithmetic: {c_out,sum} == a + b + cin, mod 2^(WIDTH+1); unsigned, no overflow flag.
// TESTING
//  1. a=8'h00,b=8'h00,cin=0, start 1 cycle -> busy 4 cycles; done after 4 edges; sum=8'h00,c_out=0.
//  2. a=8'h01,b=8'h03,cin=0 -> sum=8'h04,c_out=0. Then a=8'h03,b=8'h03,cin=1 -> sum=8'h07.
//  3. a=8'hAA,b=8'h55,cin=1 -> carry ripples through all 4 chunks: sum=8'h00,c_out=1.
//  4. a=8'hFF,b=8'hFF,cin=1 -> sum=8'hFF,c_out=1.
//     Pulse start again with a=0,b=0 during RUN -> ignored; result unchanged.
//  5. Reset: start a=8'h12,b=8'h34; drop rst_n after 2 edges
//     -> outputs 0, IDLE, no done. Re-run -> sum=8'h46.
//  6. Back-to-back: hold start through the DONE cycle with new operands a=8'h80,b=8'h80
//     -> second done 5 cycles after first; sum=8'h00,c_out=1.
//  Sweep: random a/b/cin vs a+b+cin model, WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/chunked_ripple_adder_seq.sv
// chunked_ripple_adder_seq
//
// Multi-cycle wide adder. A WIDTH-bit add is split into WIDTH/CHUNK chunks that
// are fed one per clock, LSB chunk first, through a single CHUNK-bit ripple-carry
// adder. The carry between chunks is held in a register, so one small adder
// replaces a full-width one at the cost of WIDTH/CHUNK cycles of latency.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; a/b/cin are sampled on the edge that accepts it
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   cin    in   1      carry-in to the LSB chunk
//   busy   out  1      high while chunks are being added
//   done   out  1      one-cycle pulse: sum/c_out were just updated
//   sum    out  WIDTH  result; holds until the next completion
//   c_out  out  1      carry out of the MSB chunk; holds with sum
//
// {c_out, sum} == a + b + cin (unsigned, modulo 2^(WIDTH+1)).

module chunked_ripple_adder_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // ---------------------------------------------------------------------------
  // Derived parameters
  // ---------------------------------------------------------------------------
  localparam int unsigned NumChunks = WIDTH / CHUNK;
  // A single-chunk configuration still needs a 1-bit index.
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Operands must split into whole chunks; anything else is a build error.
  if ((CHUNK == 0) || (WIDTH == 0) || ((WIDTH % CHUNK) != 0)) begin : gen_width_check
    $error("chunked_ripple_adder_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] part_q,  part_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             c_out_q, c_out_d;

  // ---------------------------------------------------------------------------
  // Chunk select: pick chunk idx of each latched operand
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned k = 0; k < NumChunks; k++) begin
      if (idx_q == IdxW'(k)) begin
        chunk_a = a_q[k*CHUNK +: CHUNK];
        chunk_b = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CHUNK-bit ripple-carry adder, fed by the registered inter-chunk carry
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;

  always_comb begin
    logic rc;
    rc        = carry_q;
    chunk_sum = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ rc;
      rc           = (chunk_a[i] & chunk_b[i]) | (rc & (chunk_a[i] ^ chunk_b[i]));
    end
    chunk_cout = rc;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    case (state_q)
      // DONE behaves like IDLE for acceptance, which is what allows
      // back-to-back adds without an idle bubble.
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          part_d  = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        // start is deliberately ignored here; operands stay as latched.
        for (int unsigned k = 0; k < NumChunks; k++) begin
          if (idx_q == IdxW'(k)) begin
            part_d[k*CHUNK +: CHUNK] = chunk_sum;
          end
        end
        carry_d = chunk_cout;

        if (idx_q == LastIdx) begin
          // Publish the complete result only now so sum never shows a partial.
          sum_d   = part_d;
          c_out_d = chunk_cout;
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    sum   = sum_q;
    c_out = c_out_q;
  end

endmodule
